insn_rom_responder: RTL and testbench

INSN_ROM_RESPONDER -- requirements
Module: insn_rom_responder

---
 rtl/insn_rom_responder_pkg.sv | 19 +
 rtl/insn_rom_responder_bcd_digit_accumulator.sv | 61 ++++++
 rtl/insn_rom_responder.sv | 112 +++++++++++
 tb/tb_insn_rom_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/insn_rom_responder_pkg.sv
// Shared parameters for the instruction ROM responder.
//   INSN_WIDTH      - default instruction word width
//   DEKATRON_WIDTH  - bits per BCD digit of the instruction pointer
//   IP_DEKATRON_NUM - number of BCD digits in the instruction pointer
//   rom_state_t     - responder FSM state encoding
package insn_rom_responder_pkg;

  localparam int INSN_WIDTH      = 4;
  localparam int DEKATRON_WIDTH  = 4;
  localparam int IP_DEKATRON_NUM = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    READ    = 2'd2,
    VALID   = 2'd3
  } rom_state_t;

endpackage

// File: rtl/insn_rom_responder_bcd_digit_accumulator.sv
// bcd_digit_accumulator: converts a latched BCD address to binary, one digit
// per clock, most significant digit first (acc <= acc*10 + digit).
// Ports:
//   Clk, Rst_n  - clock, asynchronous active-low reset
//   load        - latch bcd_in, clear acc, point idx at the MSD
//   step        - fold the current digit into acc and move toward the LSD
//   bcd_in      - BCD address, MSD in the top bits
//   acc         - binary accumulator
//   last        - current digit is the LSD (this step is the final one)
//   bad_digit   - the digit being folded in this step is not BCD (>9)
module bcd_digit_accumulator #(
  parameter int DIGITS  = 3,
  parameter int DIGIT_W = 4,
  parameter int ACC_W   = 10
) (
  input  logic                      Clk,
  input  logic                      Rst_n,
  input  logic                      load,
  input  logic                      step,
  input  logic [DIGITS*DIGIT_W-1:0] bcd_in,
  output logic [ACC_W-1:0]          acc,
  output logic                      last,
  output logic                      bad_digit
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] MSD_IDX = IDX_W'(DIGITS - 1);

  logic [DIGITS*DIGIT_W-1:0] bcd_q;
  logic [IDX_W-1:0]          idx;
  logic [DIGIT_W-1:0]        digit_raw;
  logic                      digit_ok;
  logic [DIGIT_W-1:0]        digit;

  assign digit_raw = bcd_q[idx*DIGIT_W +: DIGIT_W];
  assign digit_ok  = (digit_raw <= DIGIT_W'(9));
  // Non-BCD digits contribute 0 so the address stays inside 10**DIGITS.
  assign digit     = digit_ok ? digit_raw : '0;
  assign last      = (idx == '0);
  assign bad_digit = step && !digit_ok;

  // Address digits are data: no reset needed.
  always_ff @(posedge Clk) begin
    if (load) bcd_q <= bcd_in;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc <= '0;
      idx <= MSD_IDX;
    end else if (load) begin
      acc <= '0;
      idx <= MSD_IDX;
    end else if (step) begin
      // acc <= 10**(DIGITS-1)-1 before the final step, so this never wraps.
      acc <= ACC_W'(acc * 10 + digit);
      if (idx != '0) idx <= idx - 1'b1;
    end
  end

endmodule

// File: rtl/insn_rom_responder.sv
// insn_rom_responder: instruction ROM that answers BCD instruction-pointer
// read requests. A request latches the BCD address, converts it to binary one
// digit per clock, then reads the word into RomData and raises RomReady.
// Latency from the sampling edge to RomReady is IP_DEKATRON_NUM+1 edges.
// Ports:
//   Clk, Rst_n  - clock, asynchronous active-low reset
//   RomRequest  - read strobe; restarts any conversion in progress
//   IpAddress   - BCD address, MSD in the top bits
//   RomReady    - RomData is valid for the last requested address
//   RomData     - registered instruction word (0 for out-of-range addresses)
//   ProgWe      - program-load write strobe
//   ProgAddr    - binary write address (>= ROM_DEPTH ignored)
//   ProgData    - write data
//   AddrError   - sticky: non-BCD digit or out-of-range address seen
module insn_rom_responder #(
  parameter int          INSN_WIDTH      = insn_rom_responder_pkg::INSN_WIDTH,
  parameter int          IP_DEKATRON_NUM = insn_rom_responder_pkg::IP_DEKATRON_NUM,
  parameter int          DEKATRON_WIDTH  = insn_rom_responder_pkg::DEKATRON_WIDTH,
  parameter int unsigned ROM_DEPTH       = 1000
) (
  input  logic                                      Clk,
  input  logic                                      Rst_n,
  input  logic                                      RomRequest,
  input  logic [IP_DEKATRON_NUM*DEKATRON_WIDTH-1:0] IpAddress,
  output logic                                      RomReady,
  output logic [INSN_WIDTH-1:0]                     RomData,
  input  logic                                      ProgWe,
  input  logic [$clog2(ROM_DEPTH)-1:0]              ProgAddr,
  input  logic [INSN_WIDTH-1:0]                     ProgData,
  output logic                                      AddrError
);

  import insn_rom_responder_pkg::*;

  localparam int ACC_W = $clog2(10**IP_DEKATRON_NUM);
  localparam int AW    = $clog2(ROM_DEPTH);

  rom_state_t           state;
  logic [ACC_W-1:0]     acc;
  logic                 last;
  logic                 bad_digit;
  logic                 step;
  logic                 in_range;
  logic [AW-1:0]        rd_idx;
  logic [INSN_WIDTH-1:0] mem [ROM_DEPTH];

  // A request is accepted in every state: IDLE/VALID start a read,
  // CONVERT/READ restart it with the new address.
  assign step     = (state == CONVERT) && !RomRequest;
  assign in_range = (32'(acc) < ROM_DEPTH);
  assign rd_idx   = AW'(acc);

  bcd_digit_accumulator #(
    .DIGITS  (IP_DEKATRON_NUM),
    .DIGIT_W (DEKATRON_WIDTH),
    .ACC_W   (ACC_W)
  ) u_acc (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .load      (RomRequest),
    .step      (step),
    .bcd_in    (IpAddress),
    .acc       (acc),
    .last      (last),
    .bad_digit (bad_digit)
  );

  // Program store: never reset, so a loaded program survives Rst_n.
  always_ff @(posedge Clk) begin
    if (ProgWe && (32'(ProgAddr) < ROM_DEPTH)) mem[ProgAddr] <= ProgData;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      RomReady  <= 1'b0;
      RomData   <= '0;
      AddrError <= 1'b0;
    end else begin
      if (bad_digit) AddrError <= 1'b1;
      case (state)
        IDLE, VALID: begin
          if (RomRequest) begin
            RomReady <= 1'b0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          if (!RomRequest && last) state <= READ;
        end
        READ: begin
          if (RomRequest) begin
            state <= CONVERT;
          end else begin
            // Non-blocking read: a same-edge write to this address lands
            // after the old word has been captured.
            if (in_range) begin
              RomData <= mem[rd_idx];
            end else begin
              RomData   <= '0;
              AddrError <= 1'b1;
            end
            RomReady <= 1'b1;
            state    <= VALID;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_insn_rom_responder.sv
// Testbench for insn_rom_responder: a default instance (ROM_DEPTH=1000) and a
// shallow instance (ROM_DEPTH=500) sharing the request side. Expected read
// words are queued when a request is issued and compared when RomReady rises.
module tb_insn_rom_responder;
  import insn_rom_responder_pkg::*;

  logic        Clk;
  logic        Rst_n;
  logic        RomRequest;
  logic [11:0] IpAddress;
  logic        RomReady;
  logic [3:0]  RomData;
  logic        ProgWe;
  logic [9:0]  ProgAddr;
  logic [3:0]  ProgData;
  logic        AddrError;

  logic        RomReady2;
  logic [3:0]  RomData2;
  logic        AddrError2;
  logic        ProgWe2;
  logic [8:0]  ProgAddr2;
  logic [3:0]  ProgData2;

  int          n_checks;
  int          n_pass;
  logic [3:0]  exp_q[$];

  insn_rom_responder dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .RomRequest (RomRequest),
    .IpAddress  (IpAddress),
    .RomReady   (RomReady),
    .RomData    (RomData),
    .ProgWe     (ProgWe),
    .ProgAddr   (ProgAddr),
    .ProgData   (ProgData),
    .AddrError  (AddrError)
  );

  insn_rom_responder #(.ROM_DEPTH(500)) dut2 (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .RomRequest (RomRequest),
    .IpAddress  (IpAddress),
    .RomReady   (RomReady2),
    .RomData    (RomData2),
    .ProgWe     (ProgWe2),
    .ProgAddr   (ProgAddr2),
    .ProgData   (ProgData2),
    .AddrError  (AddrError2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic prog_write(input logic [9:0] addr, input logic [3:0] data);
    @(negedge Clk);
    ProgWe   = 1'b1;
    ProgAddr = addr;
    ProgData = data;
    @(negedge Clk);
    ProgWe   = 1'b0;
  endtask

  // Returns after the negedge following the sampling edge.
  task automatic send_req(input logic [11:0] bcd);
    @(negedge Clk);
    RomRequest = 1'b1;
    IpAddress  = bcd;
    @(negedge Clk);
    RomRequest = 1'b0;
  endtask

  // Counts edges until RomReady is seen; -1 if the budget runs out.
  task automatic wait_ready(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge Clk);
      if (RomReady) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [3:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'bxxxx;
    chk(tag, 32'(RomData), 32'(e));
  endtask

  task automatic read_check(input string tag, input logic [11:0] bcd, input logic [3:0] exp);
    int lat;
    exp_q.push_back(exp);
    send_req(bcd);
    chk({tag, "_clr"}, 32'(RomReady), 32'd0);
    wait_ready(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd4);
    sb_pop({tag, "_data"});
  endtask

  initial begin
    int   lat;
    logic ok;
    n_checks   = 0;
    n_pass     = 0;
    Rst_n      = 1'b0;
    RomRequest = 1'b0;
    IpAddress  = '0;
    ProgWe     = 1'b0;
    ProgAddr   = '0;
    ProgData   = '0;
    ProgWe2    = 1'b0;
    ProgAddr2  = '0;
    ProgData2  = '0;

    // Load program while held in reset; the store is not reset.
    prog_write(10'd0,   4'h3);
    prog_write(10'd123, 4'h7);
    prog_write(10'd5,   4'h9);
    prog_write(10'd1,   4'h1);
    prog_write(10'd999, 4'h5);

    chk("rst_ready", 32'(RomReady), 32'd0);
    chk("rst_data",  32'(RomData),  32'd0);
    chk("rst_aerr",  32'(AddrError), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));

    @(negedge Clk);
    Rst_n = 1'b1;
    ok = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      if (RomReady !== 1'b0) ok = 1'b0;
    end
    chk("post_rst_idle_ready", 32'(ok), 32'd1);

    read_check("rd000", 12'h000, 4'h3);
    chk("rd000_aerr", 32'(AddrError), 32'd0);

    read_check("rd123", 12'h123, 4'h7);
    // Hold for 20 idle cycles, with a program write landing mid-hold.
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      if (i == 5) begin
        ProgWe = 1'b1; ProgAddr = 10'd200; ProgData = 4'hA;
      end else begin
        ProgWe = 1'b0;
      end
      if (RomReady !== 1'b1 || RomData !== 4'h7) ok = 1'b0;
    end
    ProgWe = 1'b0;
    chk("rd123_hold", 32'(ok), 32'd1);
    chk("rd123_hold_state", 32'(dut.state), 32'(VALID));

    read_check("rdA05", 12'hA05, 4'h9);
    chk("rdA05_aerr", 32'(AddrError), 32'd1);
    read_check("rd001", 12'h001, 4'h1);
    chk("rd001_aerr_sticky", 32'(AddrError), 32'd1);

    // Reset clears the error flag but not the program.
    @(negedge Clk);
    Rst_n = 1'b0;
    #1;
    chk("rst2_aerr",  32'(AddrError),  32'd0);
    chk("rst2_aerr2", 32'(AddrError2), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    read_check("rd999", 12'h999, 4'h5);
    chk("rd999_aerr",   32'(AddrError),  32'd0);
    chk("rd999_ready2", 32'(RomReady2),  32'd1);
    chk("rd999_data2",  32'(RomData2),   32'd0);
    chk("rd999_aerr2",  32'(AddrError2), 32'd1);

    // Restart: second request two edges after the first.
    exp_q.push_back(4'h7);
    send_req(12'h001);
    chk("rst_req_clr", 32'(RomReady), 32'd0);
    @(negedge Clk);
    chk("rst_req_low", 32'(RomReady), 32'd0);
    RomRequest = 1'b1;
    IpAddress  = 12'h123;
    @(negedge Clk);
    RomRequest = 1'b0;
    wait_ready(lat);
    chk("restart_lat", 32'(lat), 32'd4);
    sb_pop("restart_data");

    // Same-edge write and READ of address 123.
    exp_q.push_back(4'h7);
    send_req(12'h123);
    repeat (3) @(negedge Clk);
    chk("same_edge_ready_low", 32'(RomReady), 32'd0);
    ProgWe = 1'b1; ProgAddr = 10'd123; ProgData = 4'hE;
    @(negedge Clk);
    ProgWe = 1'b0;
    chk("same_edge_ready", 32'(RomReady), 32'd1);
    sb_pop("same_edge_old");
    read_check("rd123_new", 12'h123, 4'hE);

    // Reset in the middle of a conversion.
    send_req(12'h001);
    @(negedge Clk);
    chk("mid_state_conv", 32'(dut.state), 32'(CONVERT));
    #2;
    Rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(RomReady),  32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(IDLE));
    chk("mid_rst_data",  32'(RomData),   32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    ok = 1'b1;
    repeat (10) begin
      @(negedge Clk);
      if (RomReady !== 1'b0) ok = 1'b0;
    end
    chk("mid_rst_no_ready", 32'(ok), 32'd1);
    chk("mid_rst_idle", 32'(dut.state), 32'(IDLE));

    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
